data_mem_responder: RTL and testbench

Word-addressed data memory that acts as the responder side of the CPU's load/store request interface. The core issues requests, such as the store from `SW x4, 4(x3)`, and this block accepts them, waits a programmable number of cycles, then performs the access and returns a response. It handles byte-enabled writes and flags misaligned or out-of-range accesses. It sits beside the register file and ALU in the CPU top, on the memory stage's request/response channel.

---
 rtl/data_mem_responder.sv | 173 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Word-addressed data memory acting as the responder on the CPU memory-stage
//   load/store channel. A request is accepted in IDLE, held for LATENCY wait
//   cycles, and the access is performed on the edge that enters RESP. The
//   response is then held until the consumer takes it.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, 4..4096)
//   LATENCY      wait cycles between accept and response (0..15)
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   req_valid  request present            req_ready  block can accept
//   req_we     1 = store, 0 = load        req_addr   byte address
//   req_wdata  store data                 req_be     store byte enables
//   rsp_valid  response present           rsp_ready  consumer accepts
//   rsp_rdata  load data (0 for stores/errors)
//   rsp_err    misaligned or out-of-range access
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam bit         ZERO_LAT = (LATENCY == 0);
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          we_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic          err_q;
    logic          req_ready_q;
    logic          rsp_valid_q;
    logic [31:0]   rsp_rdata_q;
    logic          rsp_err_q;

    logic [31:0]   mem [DEPTH_WORDS];

    // Request seen this cycle: error check covers misalignment and any
    // word index bit above the array range (no aliasing).
    logic          req_err;
    assign req_err = (req_addr[1:0] != 2'b00) || (|req_addr[31:AW+2]);

    // With zero latency the access happens on the accept edge, so it must use
    // the live request; otherwise it uses the latched copy.
    logic          acc_we;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_be;
    logic          acc_err;
    logic          acc_fire;
    logic          mem_we;
    logic [31:0]   rsp_rdata_d;

    always_comb begin
        if (state_q == IDLE) begin
            acc_we    = req_we;
            acc_idx   = req_addr[AW+1:2];
            acc_wdata = req_wdata;
            acc_be    = req_be;
            acc_err   = req_err;
        end else begin
            acc_we    = we_q;
            acc_idx   = idx_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
            acc_err   = err_q;
        end
        acc_fire    = ((state_q == IDLE) && req_valid && ZERO_LAT) ||
                      ((state_q == WAIT) && (cnt_q == 4'd0));
        // Gating with reset keeps a request presented during reset from writing.
        mem_we      = acc_fire && acc_we && !acc_err && reset;
        rsp_rdata_d = (!acc_we && !acc_err) ? mem[acc_idx] : 32'd0;
    end

    // Memory array: not reset; written exactly once per store, on RESP entry.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= 32'd0;
            be_q        <= 4'd0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        idx_q       <= req_addr[AW+1:2];
                        wdata_q     <= req_wdata;
                        be_q        <= req_be;
                        err_q       <= req_err;
                        req_ready_q <= 1'b0;
                        if (ZERO_LAT) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= rsp_rdata_d;
                            rsp_err_q   <= acc_err;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rsp_rdata_d;
                        rsp_err_q   <= acc_err;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'd0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Drives two responders (LATENCY=2 and LATENCY=0) and compares every
//   response against a word-array reference model of the memory.
module tb_data_mem_responder;

    localparam int DEPTH = 256;

    logic        clk;
    logic        reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int          n_assert = 0;
    int          n_fail   = 0;
    int          lat [2]  = '{2, 0};
    logic [31:0] mdl [2][DEPTH];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_lat2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_lat0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input int sel, input string tag);
        chk({tag, "_req_ready"}, {31'd0, req_ready[sel]}, 32'd1);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid[sel]}, 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata[sel], 32'd0);
        chk({tag, "_rsp_err"},   {31'd0, rsp_err[sel]},   32'd0);
    endtask

    // One complete transaction, starting and ending at a negedge with the DUT idle.
    task automatic txn(input int sel, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int hold);
        logic        err;
        logic [31:0] exp_rd;
        int          idx;
        err    = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(DEPTH));
        idx    = int'(addr[31:2]);
        exp_rd = 32'd0;
        if (!err && !we) exp_rd = mdl[sel][idx];
        if (!err && we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mdl[sel][idx][8*b +: 8] = wdata[8*b +: 8];
        end
        chk("req_ready_before", {31'd0, req_ready[sel]}, 32'd1);
        req_we[sel]    = we;
        req_addr[sel]  = addr;
        req_wdata[sel] = wdata;
        req_be[sel]    = be;
        req_valid[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[sel] = 1'b0;
        req_addr[sel]  = $urandom();
        req_wdata[sel] = $urandom();
        req_be[sel]    = 4'($urandom());
        req_we[sel]    = ~we;
        for (int k = 0; k < lat[sel]; k++) begin
            chk("rsp_valid_wait", {31'd0, rsp_valid[sel]}, 32'd0);
            chk("req_ready_wait", {31'd0, req_ready[sel]}, 32'd0);
            @(negedge clk);
        end
        chk("rsp_valid",  {31'd0, rsp_valid[sel]}, 32'd1);
        chk("rsp_rdata",  rsp_rdata[sel], exp_rd);
        chk("rsp_err",    {31'd0, rsp_err[sel]}, {31'd0, err});
        chk("req_ready_resp", {31'd0, req_ready[sel]}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_rsp_valid", {31'd0, rsp_valid[sel]}, 32'd1);
            chk("hold_rsp_rdata", rsp_rdata[sel], exp_rd);
            chk("hold_rsp_err",   {31'd0, rsp_err[sel]}, {31'd0, err});
            chk("hold_req_ready", {31'd0, req_ready[sel]}, 32'd0);
        end
        rsp_ready[sel] = 1'b1;
        @(negedge clk);
        rsp_ready[sel] = 1'b0;
        chk_idle_outputs(sel, "after_hs");
    endtask

    initial begin
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0; req_we[s] = 1'b0; req_addr[s] = 32'd0;
            req_wdata[s] = 32'd0; req_be[s] = 4'd0; rsp_ready[s] = 1'b0;
        end

        // Reset held for 3 cycles, outputs checked during and after.
        repeat (3) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) chk_idle_outputs(s, "in_reset");
        end
        reset = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) chk_idle_outputs(s, "post_reset");

        // Preload the low words so later loads have known contents.
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 16; i++)
                txn(s, 1'b1, 32'(i * 4), $urandom(), 4'hF, 0);

        for (int s = 0; s < 2; s++) begin
            // Store then load of the same word.
            txn(s, 1'b1, 32'h8, 32'h0000_0004, 4'hF, 0);
            txn(s, 1'b0, 32'h8, 32'h0, 4'h0, 0);
            // Byte enables.
            txn(s, 1'b1, 32'h8, 32'h1122_3344, 4'hF, 0);
            txn(s, 1'b1, 32'h8, 32'hAABB_CCDD, 4'b0101, 0);
            txn(s, 1'b0, 32'h8, 32'h0, 4'h0, 0);
            // Error cases.
            txn(s, 1'b0, 32'h6, 32'h0, 4'h0, 0);
            txn(s, 1'b1, 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF, 0);
            txn(s, 1'b0, 32'h0, 32'h0, 4'h0, 0);
            txn(s, 1'b1, 32'h4, 32'h5555_AAAA, 4'b0000, 0);
            txn(s, 1'b0, 32'h4, 32'h0, 4'h0, 0);
            // Back-pressure on a load, then on a store followed by a load.
            txn(s, 1'b0, 32'h8, 32'h0, 4'h0, 5);
            txn(s, 1'b1, 32'h10, 32'h0BAD_F00D, 4'b1001, 5);
            txn(s, 1'b0, 32'h10, 32'h0, 4'h0, 0);
        end

        // Reset while a store sits in WAIT: the store must be dropped.
        req_we[0] = 1'b1; req_addr[0] = 32'hC; req_wdata[0] = 32'hDEAD_BEEF;
        req_be[0] = 4'hF; req_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("wait_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        reset = 1'b0;
        #1;
        chk_idle_outputs(0, "async_reset_wait");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_idle_outputs(0, "after_reset_wait");
        txn(0, 1'b0, 32'hC, 32'h0, 4'h0, 0);

        // Zero-latency: response visible right after accept; reset in RESP
        // still leaves the committed store in memory.
        req_we[1] = 1'b1; req_addr[1] = 32'hC; req_wdata[1] = 32'hDEAD_BEEF;
        req_be[1] = 4'hF; req_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        mdl[1][3] = 32'hDEAD_BEEF;
        chk("lat0_rsp_valid", {31'd0, rsp_valid[1]}, 32'd1);
        chk("lat0_rsp_rdata", rsp_rdata[1], 32'd0);
        reset = 1'b0;
        #1;
        chk_idle_outputs(1, "async_reset_resp");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        txn(1, 1'b0, 32'hC, 32'h0, 4'h0, 0);

        // Randomized traffic on both instances.
        for (int n = 0; n < 60; n++) begin
            int          s;
            int          mode;
            logic [31:0] a;
            s    = n % 2;
            mode = int'($urandom_range(0, 9));
            a    = 32'($urandom_range(0, 15)) * 32'd4;
            if (mode == 0) a = a + 32'($urandom_range(1, 3));
            else if (mode == 1) a = 32'(DEPTH * 4) + ($urandom() & 32'hFFFF_FFFC);
            txn(s, 1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom()),
                int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
